// File: rtl/move_engine_pkg.sv
// Shared constants, state encoding and board-access helpers for the 2048 move engine.
package game2048_pkg;

  localparam int N       = 4;
  localparam int EXP_W   = 4;
  localparam int CELLS   = N * N;
  localparam int LINE_W  = N * EXP_W;
  localparam int BOARD_W = CELLS * EXP_W;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;

  typedef logic [BOARD_W-1:0] board_t;
  typedef logic [EXP_W-1:0]   exp_t;

  typedef enum logic [2:0] {
    INIT0  = 3'd0,
    INIT1  = 3'd1,
    IDLE   = 3'd2,
    LINE   = 3'd3,
    SPAWN  = 3'd4,
    COMMIT = 3'd5,
    CHECK  = 3'd6,
    OVER   = 3'd7
  } state_t;

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Cell 0 (top-left) lives in the most significant nibble
  function automatic exp_t board_slice(input board_t board, input logic [3:0] idx);
    return board[(4'd15 - idx) * EXP_W +: EXP_W];
  endfunction

  function automatic board_t board_put(input board_t board, input logic [3:0] idx, input exp_t val);
    board_t b;
    b = board;
    b[(4'd15 - idx) * EXP_W +: EXP_W] = val;
    return b;
  endfunction

endpackage

// File: rtl/move_engine_if.sv
// Board/handshake bundle between the move engine and the box registers.
interface move_engine_if;
  import game2048_pkg::*;

  logic [3:0] direction;
  board_t     oldvalues;
  logic       enable;
  board_t     newvalues;
  logic       endstatus;
  logic       won;

  modport master (
    output direction,
    output oldvalues,
    input  enable,
    input  newvalues,
    input  endstatus,
    input  won
  );

  modport slave (
    input  direction,
    input  oldvalues,
    output enable,
    output newvalues,
    output endstatus,
    output won
  );

endinterface

// File: rtl/move_engine_merge_line.sv
// Combinational slide-and-merge of one 4-cell line; cell 0 is the end tiles slide toward.
module merge_line
  import game2048_pkg::*;
(
  input  logic [LINE_W-1:0] line_in,
  output logic [LINE_W-1:0] line_out
);

  // one spare zero nibble on top so the last cell has a harmless neighbour
  logic [LINE_W+EXP_W-1:0] packed_s;

  // Slide non-empty cells toward index 0, keeping their order
  always_comb begin
    logic [2:0] fill_s;
    packed_s = '0;
    fill_s   = 3'd0;
    for (int k = 0; k < N; k++) begin
      if (line_in[k*EXP_W +: EXP_W] != 4'd0) begin
        packed_s[fill_s*EXP_W +: EXP_W] = line_in[k*EXP_W +: EXP_W];
        fill_s = fill_s + 3'd1;
      end else begin
        fill_s = fill_s;
      end
    end
  end

  // Merge equal neighbours from index 0 upward; a merged cell is consumed for this move
  always_comb begin
    logic [2:0]       put_s;
    logic             skip_s;
    logic [EXP_W-1:0] cur_s;
    logic [EXP_W-1:0] nxt_s;
    line_out = '0;
    put_s    = 3'd0;
    skip_s   = 1'b0;
    cur_s    = 4'd0;
    nxt_s    = 4'd0;
    for (int k = 0; k < N; k++) begin
      cur_s = packed_s[k*EXP_W +: EXP_W];
      nxt_s = packed_s[(k+1)*EXP_W +: EXP_W];
      if (skip_s) begin
        skip_s = 1'b0;
      end else if ((cur_s != 4'd0) && (cur_s == nxt_s) && (cur_s != EXP_MAX)) begin
        line_out[put_s*EXP_W +: EXP_W] = cur_s + 4'd1;
        put_s  = put_s + 3'd1;
        skip_s = 1'b1;
      end else if (cur_s != 4'd0) begin
        line_out[put_s*EXP_W +: EXP_W] = cur_s;
        put_s = put_s + 3'd1;
      end else begin
        skip_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/move_engine.sv
// 2048 move engine: opening board, line-by-line slide/merge, tile spawn, commit and end-of-game check.
module move_engine
  import game2048_pkg::*;
#(
  parameter int          WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)
(
  input  logic         clock,
  input  logic         start,
  move_engine_if.slave bus
);

  localparam logic [3:0] MASK_LEFT  = 4'b0001 << DIR_LEFT;
  localparam logic [3:0] MASK_RIGHT = 4'b0001 << DIR_RIGHT;
  localparam logic [3:0] MASK_UP    = 4'b0001 << DIR_UP;

  state_t      state_r, state_s;
  logic [15:0] lfsr_r;
  logic [3:0]  dir_prev_r;
  logic [3:0]  dir_lat_r, dir_lat_s;
  board_t      old_lat_r, old_lat_s;
  board_t      work_r, work_s;
  logic [1:0]  line_r, line_s;
  logic [3:0]  scan_r, scan_s;
  logic        enable_r, enable_s;
  board_t      newvalues_r, newvalues_s;
  logic        endstatus_r, endstatus_s;
  logic        won_r, won_s;

  logic              request_s;
  logic              dir_onehot_s;
  exp_t              spawn_exp_s;
  logic [LINE_W-1:0] line_pos_s;
  logic [LINE_W-1:0] line_in_s;
  logic [LINE_W-1:0] line_out_s;
  board_t            work_line_s;
  logic              board_win_s;
  logic              board_lost_s;

  assign bus.enable    = enable_r;
  assign bus.newvalues = newvalues_r;
  assign bus.endstatus = endstatus_r;
  assign bus.won       = won_r;

  // a fresh key press: exactly one bit set now, nothing held last cycle
  assign dir_onehot_s = (bus.direction != 4'd0) &&
                        ((bus.direction & (bus.direction - 4'd1)) == 4'd0);
  assign request_s    = dir_onehot_s && (dir_prev_r == 4'd0);
  assign spawn_exp_s  = (lfsr_r[7:4] == 4'd0) ? 4'd2 : 4'd1;

  // Free-running LFSR and key history, both independent of the FSM state
  always_ff @(posedge clock) begin
    if (start) begin
      lfsr_r     <= LFSR_SEED;
      dir_prev_r <= 4'd0;
    end else begin
      lfsr_r     <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
      dir_prev_r <= bus.direction;
    end
  end

  // Map the current line onto board cell indices in slide order and gather its cells
  always_comb begin
    line_pos_s = '0;
    line_in_s  = '0;
    for (int k = 0; k < N; k++) begin
      if (dir_lat_r == MASK_LEFT) begin
        line_pos_s[k*EXP_W +: EXP_W] = cell_index(line_r, 2'(k));
      end else if (dir_lat_r == MASK_RIGHT) begin
        line_pos_s[k*EXP_W +: EXP_W] = cell_index(line_r, 2'(N - 1 - k));
      end else if (dir_lat_r == MASK_UP) begin
        line_pos_s[k*EXP_W +: EXP_W] = cell_index(2'(k), line_r);
      end else begin
        line_pos_s[k*EXP_W +: EXP_W] = cell_index(2'(N - 1 - k), line_r);
      end
      line_in_s[k*EXP_W +: EXP_W] = board_slice(work_r, line_pos_s[k*EXP_W +: EXP_W]);
    end
  end

  merge_line u_merge_line (
    .line_in  (line_in_s),
    .line_out (line_out_s)
  );

  // Scatter the merged line back into a copy of the working board
  always_comb begin
    work_line_s = work_r;
    for (int k = 0; k < N; k++) begin
      work_line_s = board_put(work_line_s, line_pos_s[k*EXP_W +: EXP_W],
                              line_out_s[k*EXP_W +: EXP_W]);
    end
  end

  // Win/loss evaluation of the committed working board
  always_comb begin
    logic has_empty_s;
    logic has_pair_s;
    exp_t cell_s;
    board_win_s = 1'b0;
    has_empty_s = 1'b0;
    has_pair_s  = 1'b0;
    cell_s      = 4'd0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        cell_s      = board_slice(work_r, cell_index(2'(r), 2'(c)));
        board_win_s = board_win_s | (cell_s >= 4'(WIN_EXP));
        has_empty_s = has_empty_s | (cell_s == 4'd0);
        has_pair_s  = has_pair_s |
                      ((c < N - 1) && (cell_s == board_slice(work_r, cell_index(2'(r), 2'(c + 1))))) |
                      ((r < N - 1) && (cell_s == board_slice(work_r, cell_index(2'(r + 1), 2'(c)))));
      end
    end
    board_lost_s = !has_empty_s && !has_pair_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_s     = state_r;
    dir_lat_s   = dir_lat_r;
    old_lat_s   = old_lat_r;
    work_s      = work_r;
    line_s      = line_r;
    scan_s      = scan_r;
    enable_s    = 1'b0;
    newvalues_s = newvalues_r;
    endstatus_s = endstatus_r;
    won_s       = won_r;
    case (state_r)
      INIT0: begin
        work_s  = board_put('0, lfsr_r[3:0], spawn_exp_s);
        scan_s  = lfsr_r[7:4];
        state_s = INIT1;
      end
      INIT1, SPAWN: begin
        if (board_slice(work_r, scan_r) == 4'd0) begin
          work_s  = board_put(work_r, scan_r, spawn_exp_s);
          state_s = COMMIT;
        end else begin
          scan_s = scan_r + 4'd1;
        end
      end
      IDLE: begin
        if (request_s) begin
          dir_lat_s = bus.direction;
          old_lat_s = bus.oldvalues;
          work_s    = bus.oldvalues;
          line_s    = 2'd0;
          state_s   = LINE;
        end else begin
          state_s = IDLE;
        end
      end
      LINE: begin
        work_s = work_line_s;
        line_s = line_r + 2'd1;
        if (line_r != 2'd3) begin
          state_s = LINE;
        end else if (work_line_s == old_lat_r) begin
          state_s = IDLE;
        end else begin
          scan_s  = lfsr_r[3:0];
          state_s = SPAWN;
        end
      end
      COMMIT: begin
        newvalues_s = work_r;
        enable_s    = 1'b1;
        state_s     = CHECK;
      end
      CHECK: begin
        if (board_win_s || board_lost_s) begin
          endstatus_s = 1'b1;
          won_s       = board_win_s;
          state_s     = OVER;
        end else begin
          state_s = IDLE;
        end
      end
      OVER: begin
        state_s = OVER;
      end
      default: begin
        state_s = INIT0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (start) begin
      state_r     <= INIT0;
      dir_lat_r   <= 4'd0;
      old_lat_r   <= '0;
      work_r      <= '0;
      line_r      <= 2'd0;
      scan_r      <= 4'd0;
      enable_r    <= 1'b0;
      newvalues_r <= '0;
      endstatus_r <= 1'b0;
      won_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      dir_lat_r   <= dir_lat_s;
      old_lat_r   <= old_lat_s;
      work_r      <= work_s;
      line_r      <= line_s;
      scan_r      <= scan_s;
      enable_r    <= enable_s;
      newvalues_r <= newvalues_s;
      endstatus_r <= endstatus_s;
      won_r       <= won_s;
    end
  end

endmodule

// File: tb/tb_move_engine.sv
// Scoreboard bench for move_engine: stimulus queues expected boards, a monitor checks each enable.
module tb_move_engine;
  import game2048_pkg::*;

  localparam logic [3:0] D_UP    = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  typedef struct {
    logic [63:0] board;
    int          n_spawn;
    logic        fin;
    logic        win;
  } exp_entry_t;

  logic clock;
  logic start;
  move_engine_if bus ();

  move_engine #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) dut (
    .clock (clock),
    .start (start),
    .bus   (bus)
  );

  exp_entry_t sb_q[$];
  exp_entry_t cur;
  logic       pend;
  int         errors;
  int         checks;
  int         enable_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Compare a committed board: fixed cells exact, spawned cells only in expected-empty slots
  task automatic check_board(input exp_entry_t e, input logic [63:0] act);
    logic [63:0] stripped;
    logic [3:0]  a;
    logic [3:0]  x;
    int          spawned;
    stripped = act;
    spawned  = 0;
    for (int i = 0; i < 16; i++) begin
      a = act[(15 - i) * 4 +: 4];
      x = e.board[(15 - i) * 4 +: 4];
      if (a !== x && x == 4'd0 && (a == 4'd1 || a == 4'd2)) begin
        stripped[(15 - i) * 4 +: 4] = 4'd0;
        spawned++;
      end
    end
    check("board", stripped, e.board);
    check("spawn_count", 64'(spawned), 64'(e.n_spawn));
  endtask

  // Monitor: every enable pops one expectation; the following cycle checks pulse width and status
  always @(negedge clock) begin
    if (pend) begin
      pend = 1'b0;
      check("enable_width", 64'(bus.enable), 64'd0);
      check("endstatus", 64'(bus.endstatus), 64'(cur.fin));
      check("won", 64'(bus.won), 64'(cur.win));
    end else if (bus.enable === 1'b1) begin
      enable_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got newvalues %h with no move pending", bus.newvalues);
      end else begin
        cur = sb_q.pop_front();
        check_board(cur, bus.newvalues);
        pend = 1'b1;
      end
    end
  end

  task automatic wait_enables(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (enable_cnt < target && n < bound) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (enable_cnt < target) begin
      errors++;
      $display("FAIL %s: enable count %0d, required %0d within %0d cycles", name, enable_cnt, target, bound);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic push_exp(input logic [63:0] b, input int ns, input logic fin, input logic win);
    exp_entry_t e;
    e.board   = b;
    e.n_spawn = ns;
    e.fin     = fin;
    e.win     = win;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    int tgt;
    @(negedge clock);
    start = 1'b1;
    bus.direction = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_enable", 64'(bus.enable), 64'd0);
    check("rst_newvalues", bus.newvalues, 64'd0);
    check("rst_endstatus", 64'(bus.endstatus), 64'd0);
    check("rst_won", 64'(bus.won), 64'd0);
    tgt = enable_cnt + 1;
    push_exp(64'd0, 2, 1'b0, 1'b0);
    start = 1'b0;
    wait_enables(tgt, 36, "opening_enable");
  endtask

  task automatic do_move(input logic [63:0] old, input logic [3:0] dir, input logic [63:0] exp_b,
                         input logic fin, input logic win, input string name);
    int tgt;
    tgt = enable_cnt + 1;
    push_exp(exp_b, 1, fin, win);
    @(negedge clock);
    bus.oldvalues = old;
    bus.direction = dir;
    @(negedge clock);
    bus.direction = 4'd0;
    wait_enables(tgt, 24, name);
  endtask

  initial begin
    int cnt0;
    errors        = 0;
    checks        = 0;
    enable_cnt    = 0;
    pend          = 1'b0;
    start         = 1'b1;
    bus.direction = 4'd0;
    bus.oldvalues = 64'd0;

    do_reset();

    do_move(64'h1122_0000_0000_0000, D_LEFT,  64'h2300_0000_0000_0000, 1'b0, 1'b0, "left_merge");
    do_move(64'h1111_0000_0000_0000, D_LEFT,  64'h2200_0000_0000_0000, 1'b0, 1'b0, "left_no_double");
    do_move(64'h1110_0000_0000_0000, D_RIGHT, 64'h0012_0000_0000_0000, 1'b0, 1'b0, "right_no_double");
    do_move(64'h0000_0030_0000_0300, D_UP,    64'h0330_0000_0000_0000, 1'b0, 1'b0, "up_slide");

    // no-op left, then a real move requested at cycle 6
    cnt0 = enable_cnt;
    @(negedge clock);
    bus.oldvalues = 64'h1000_2000_3000_4000;
    bus.direction = D_LEFT;
    @(negedge clock);
    bus.direction = 4'd0;
    repeat (5) @(negedge clock);
    check("noop_no_enable", 64'(enable_cnt - cnt0), 64'd0);
    push_exp(64'h0000_0000_0000_1000, 1, 1'b0, 1'b0);
    bus.oldvalues = 64'h1000_0000_0000_0000;
    bus.direction = D_DOWN;
    @(negedge clock);
    bus.direction = 4'd0;
    wait_enables(cnt0 + 1, 24, "after_noop_down");

    // held key yields exactly one move
    cnt0 = enable_cnt;
    push_exp(64'h2000_0000_0000_0000, 1, 1'b0, 1'b0);
    @(negedge clock);
    bus.oldvalues = 64'h1100_0000_0000_0000;
    bus.direction = D_LEFT;
    repeat (100) @(negedge clock);
    bus.direction = 4'd0;
    repeat (4) @(negedge clock);
    check("held_single_move", 64'(enable_cnt - cnt0), 64'd1);

    // win, then further presses are ignored
    do_move(64'hAA00_0000_0000_0000, D_LEFT, 64'hB000_0000_0000_0000, 1'b1, 1'b1, "win");
    cnt0 = enable_cnt;
    for (int p = 0; p < 3; p++) begin
      @(negedge clock);
      bus.oldvalues = 64'h1100_0000_0000_0000;
      bus.direction = (p == 1) ? D_RIGHT : D_LEFT;
      @(negedge clock);
      bus.direction = 4'd0;
      repeat (25) @(negedge clock);
    end
    check("over_no_enable", 64'(enable_cnt - cnt0), 64'd0);
    check("over_endstatus", 64'(bus.endstatus), 64'd1);

    // reset from a finished game, then a losing move
    do_reset();
    do_move(64'h3434_4343_3434_0565, D_LEFT, 64'h3434_4343_3434_5650, 1'b1, 1'b0, "loss");

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_engine.md
# move_engine

Sequential game-logic stage for the 2048 board. Sits directly upstream of the sixteen box registers: it samples the current board (`oldvalues`) and the direction input, then slides and merges tiles one line per cycle and spawns a new tile. It writes the result back to the boxes with a one-cycle `enable` pulse and flags end of game on `endstatus`. It also generates the two-tile opening board after reset.

## Interface
- `WIN_EXP`, 11: tile exponent that wins the game (2^11 = 2048).
- `LFSR_SEED`, 16'hACE1: LFSR value loaded on reset.
- `clock` in 1: system clock; all state is on the rising edge.
- `start` in 1: reset, synchronous, active-high.
- `direction` in 4: one-hot move request, bit 3 up, bit 2 down, bit 1 left, bit 0 right.
- `oldvalues` in 64: current board, row-major.
  - Box1 (top-left) at [63:60], box16 (bottom-right) at [3:0].
  - Each cell is a 4-bit exponent; 0 means empty, k means tile 2^k.
- `enable` out 1: one-cycle write strobe to the boxes.
- `newvalues` out 64: board to write; same packing as `oldvalues`.
- `endstatus` out 1: game over, either won or lost; sticky until reset.
- `won` out 1: high together with `endstatus` when the game ended by a win.

## Operation
- **Reset** (`start`=1):
  - `enable`=0, `newvalues`=0, `endstatus`=0, `won`=0.
  - LFSR=`LFSR_SEED`, state=INIT0, direction history cleared.
- **LFSR**: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including while busy.
- **Move request**: `direction` has exactly one bit set, and the registered previous `direction` was 4'b0. Zero or multi-bit values are ignored. A held key does not repeat.
- **States**:
  - **INIT0, INIT1**: each spawns one tile into the working board (starting from all-zero). Then go to COMMIT.
  - **IDLE**: wait for a move request.
    - On a request, latch the direction, copy `oldvalues` into the working board, set line=0, go to LINE.
  - **LINE**: process line `line` of the working board, one per cycle, 4 cycles.
    - Left: row i, cells in order col0..col3.
    - Right: row i, col3..col0.
    - Up: column i, row0..row3.
    - Down: column i, row3..row0.
    - Compress non-zero cells toward index 0, then merge equal adjacent pairs from index 0 upward. A cell merges at most once per move; the merged exponent is e+1.
    - Exponent 15 never merges, so there is no overflow.
    - Write the result back in the same order.
    - After line 3: if working equals the latched `oldvalues`, return to IDLE with no `enable`. Otherwise go to SPAWN.
  - **SPAWN**: scan for an empty cell.
    - Start at index `lfsr[3:0]` and advance one cell per cycle with wrap 15→0.
    - On the first empty cell, write exponent 2 if `lfsr[7:4]`==0, else 1.
    - A real move always leaves at least one empty cell, so the scan completes in ≤16 cycles.
  - **COMMIT**: drive `newvalues`=working and `enable`=1 for one cycle. Go to CHECK.
  - **CHECK**: evaluate the working board.
    - won = any cell ≥ `WIN_EXP`.
    - lost = no empty cell and no horizontally or vertically adjacent equal pair.
    - If either holds: set `endstatus`, set `won` if won, go to OVER. Otherwise go to IDLE.
  - **OVER**: ignore `direction` until reset.
- `newvalues` holds its last committed value between commits.

## Timing
- Request detected on cycle 0 (IDLE). LINE occupies cycles 1–4. SPAWN occupies 1–16 cycles. COMMIT (`enable`) follows. `endstatus` is valid the cycle after `enable`.
- Worst-case latency from request to `enable`: 22 cycles. No-op move: back in IDLE at cycle 5.
- After reset release, the first `enable` is at most 34 cycles later.
- `direction` changes while busy are ignored, but history still updates. A key held through the whole move does not retrigger.
- `oldvalues` is sampled only on the request cycle.
- Reset asserted mid-move aborts immediately. No `enable` is issued, and INIT restarts on release.

## Structure
- `game2048_pkg`:
  - constants: `N`=4, `EXP_W`=4, `DIR_UP`/`DIR_DOWN`/`DIR_LEFT`/`DIR_RIGHT` bit indices, LFSR taps
  - state enum: INIT0, INIT1, IDLE, LINE, SPAWN, COMMIT, CHECK, OVER
  - helpers: cell index(row,col) and board slice
- Sub-module `merge_line`: combinational 4-cell compress+merge, used once per LINE cycle.

## Test plan
- **Reset/opening board**: `start`=1 for 2 cycles → outputs 0. After release → exactly one `enable` within 34 cycles, with exactly two non-zero cells, each 1 or 2.
- **Left merge**: row0=[1,1,2,2], rest 0, `direction`=4'b0010 pulse → row0=[2,3,0,0] plus one spawned tile in an empty cell. `enable` high for exactly 1 cycle.
- **No double merge**: row0=[1,1,1,1] left → [2,2,0,0]. Row0=[1,1,1,0] right → [0,0,1,2].
- **No-op**: tiles only in column 0, left pressed → no `enable`, next request is accepted at cycle 6. Holding `direction` for 100 cycles yields a single move.
- **Win**: row0=[10,10,0,0] left → cell0=11, `endstatus`=1, `won`=1. Later direction pulses produce no `enable`.
- **Loss**:
  - Board rows [3,4,3,4] / [4,3,4,3] / [3,4,3,4] / [0,5,6,5], left → row3=[5,6,5,x] with x∈{1,2}.
  - Response: `endstatus`=1, `won`=0.
